// File: rtl/vga_embarcacao_render.sv
// Ship renderer for the Batalha Naval VGA path: decodes grid positions into pixel boxes and
// commits them atomically at a frame start. Optional blinking of hit cells: VGA_EMBARCACAO_BLINK_EN.
module vga_embarcacao_render #(
   parameter int         NUM_CELLS    = 4,
   parameter int         GRID_N       = 8,
   parameter int         X0           = 16,
   parameter int         Y0           = 16,
   parameter int         PITCH_X      = 62,
   parameter int         PITCH_Y      = 57,
   parameter int         CELL_W       = 54,
   parameter int         CELL_H       = 49,
   parameter logic [2:0] COR          = 3'b101,
   parameter logic [2:0] COR_HIT      = 3'b111,
   parameter int         BLINK_FRAMES = 30
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   areaAtiva,
   input  logic [9:0]             linha,
   input  logic [9:0]             coluna,
   input  logic                   inicioQuadro,
   input  logic [8*NUM_CELLS-1:0] posicoesEmbarcacao,
   input  logic [NUM_CELLS-1:0]   acertos,
   input  logic                   atualiza,
   output logic                   pronto,
   output logic                   ocupado,
   output logic                   rgb_r,
   output logic                   rgb_g,
   output logic                   rgb_b
);

   if (NUM_CELLS < 1 || NUM_CELLS > 5 || BLINK_FRAMES < 1) begin : gBadParams
      $error("vga_embarcacao_render: NUM_CELLS must be 1..5 and BLINK_FRAMES >= 1");
   end

   typedef enum logic [1:0] {IDLE, WAIT_FRAME, DECODE, COMMIT} state_t;

   state_t                 state, stateNext;
   logic [2:0]             idx;
   logic                   pend;
   logic                   inicioPrev;
   logic                   frameStart;
   logic [8*NUM_CELLS-1:0] bufPos, pendPos;
   logic [NUM_CELLS-1:0]   bufHit, pendHit;
   logic [NUM_CELLS-1:0]   shEn, shHit, liveEn, liveHit;
   logic [10:0]            shLeft [NUM_CELLS], shRight [NUM_CELLS], shTop [NUM_CELLS], shBot [NUM_CELLS];
   logic [10:0]            liveLeft [NUM_CELLS], liveRight [NUM_CELLS], liveTop [NUM_CELLS], liveBot [NUM_CELLS];
   logic [7:0]             curPos;
   logic [3:0]             cx, cy;
   logic                   cellValid, lastCell;
   logic [10:0]            cLeft, cTop;
   logic [10:0]            lin11, col11;
   logic                   anyHit, anyIntact, hitVisible;
   logic [2:0]             colour, rgbQ;

   // A held strobe counts once, on its rising edge.
   assign frameStart = inicioQuadro & ~inicioPrev;
   assign lastCell   = (idx == 3'(NUM_CELLS - 1));

   always_ff @(posedge clk) begin
      // NOTE: every clocked assignment is non-blocking so all registers update from pre-edge values.
      if (rst) state <= IDLE;
      else     state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:       if (atualiza)   stateNext = WAIT_FRAME;
         WAIT_FRAME: if (frameStart) stateNext = DECODE;
         DECODE:     if (lastCell)   stateNext = COMMIT;
         COMMIT:     stateNext = (pend || atualiza) ? WAIT_FRAME : IDLE;
         default:    stateNext = IDLE;
      endcase
   end

   always_comb begin
      pronto  = (state == COMMIT);
      ocupado = (state != IDLE) || pend;
   end

   always_comb begin
      // NOTE: defaults first so no path leaves a variable unassigned and infers a latch.
      curPos = '0;
      for (int i = 0; i < NUM_CELLS; i++)
         if (int'(idx) == i) curPos = bufPos[8*i +: 8];
      cx        = curPos[3:0];
      cy        = curPos[7:4];
      cellValid = (int'(cx) >= 1) && (int'(cx) <= GRID_N) && (int'(cy) >= 1) && (int'(cy) <= GRID_N);
      cLeft     = 11'(X0 + (int'(cx) - 1) * PITCH_X);
      cTop      = 11'(Y0 + (GRID_N - int'(cy)) * PITCH_Y);
   end

   // Control and enable state; only these need reset to make every cell draw nothing.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx        <= '0;
         pend       <= 1'b0;
         inicioPrev <= 1'b0;
         shEn       <= '0;
         shHit      <= '0;
         liveEn     <= '0;
         liveHit    <= '0;
      end else begin
         inicioPrev <= inicioQuadro;
         idx        <= (state == DECODE) ? idx + 3'd1 : 3'd0;
         if (state == COMMIT)                     pend <= 1'b0;
         else if (atualiza && (state != IDLE))    pend <= 1'b1;
         if (state == DECODE)
            for (int i = 0; i < NUM_CELLS; i++)
               if (int'(idx) == i) begin
                  shEn[i]  <= cellValid;
                  shHit[i] <= bufHit[i];
               end
         if (state == COMMIT) begin
            liveEn  <= shEn;
            liveHit <= shHit;
         end
      end
   end

   // NOTE: buffers and bounds carry no reset; they are ignored until an enable bit qualifies them.
   always_ff @(posedge clk) begin
      if (atualiza && (state == IDLE || state == COMMIT)) begin
         bufPos <= posicoesEmbarcacao;
         bufHit <= acertos;
      end else if (state == COMMIT && pend) begin
         bufPos <= pendPos;
         bufHit <= pendHit;
      end
      if (atualiza && (state == WAIT_FRAME || state == DECODE)) begin
         pendPos <= posicoesEmbarcacao;
         pendHit <= acertos;
      end
      if (state == DECODE)
         for (int i = 0; i < NUM_CELLS; i++)
            if (int'(idx) == i) begin
               shLeft[i]  <= cLeft;
               shRight[i] <= cLeft + 11'(CELL_W);
               shTop[i]   <= cTop;
               shBot[i]   <= cTop + 11'(CELL_H);
            end
      if (state == COMMIT)
         for (int i = 0; i < NUM_CELLS; i++) begin
            liveLeft[i]  <= shLeft[i];
            liveRight[i] <= shRight[i];
            liveTop[i]   <= shTop[i];
            liveBot[i]   <= shBot[i];
         end
   end

`ifdef VGA_EMBARCACAO_BLINK_EN
   logic [15:0] frameCnt;
   logic        phase;

   always_ff @(posedge clk) begin
      if (rst) begin
         frameCnt <= '0;
         phase    <= 1'b0;
      end else if (frameStart) begin
         if (frameCnt == 16'(BLINK_FRAMES - 1)) begin
            frameCnt <= '0;
            phase    <= ~phase;
         end else begin
            frameCnt <= frameCnt + 16'd1;
         end
      end
   end

   assign hitVisible = ~phase;
`else
   assign hitVisible = 1'b1;
`endif

   always_comb begin
      lin11     = {1'b0, linha};
      col11     = {1'b0, coluna};
      anyHit    = 1'b0;
      anyIntact = 1'b0;
      for (int i = 0; i < NUM_CELLS; i++)
         if (liveEn[i] && (liveTop[i] < lin11) && (lin11 < liveBot[i]) &&
             (liveLeft[i] < col11) && (col11 < liveRight[i])) begin
            if (liveHit[i]) anyHit    = 1'b1;
            else            anyIntact = 1'b1;
         end
      // A blanked hit cell lets an intact cell underneath show through.
      if (anyHit && hitVisible) colour = COR_HIT;
      else if (anyIntact)       colour = COR;
      else                      colour = 3'b000;
   end

   always_ff @(posedge clk) begin
      if (rst)            rgbQ <= 3'b000;
      else if (areaAtiva) rgbQ <= colour;
      else                rgbQ <= 3'b000;
   end

   assign rgb_r = rgbQ[2];
   assign rgb_g = rgbQ[1];
   assign rgb_b = rgbQ[0];

endmodule

// File: doc/vga_embarcacao_render.md
# vga_embarcacao_render

Parametrised ship renderer for the Batalha Naval VGA path. Draws a ship of `NUM_CELLS` grid cells of a configurable colour over the 640x480 active area, with hit cells shown in a separate colour. Position updates are taken through a request/acknowledge handshake, decoded sequentially into shadow registers, and committed atomically at a frame boundary, so a ship never tears mid-frame. Sits between the game-state logic and the VGA colour mux, one instance per ship.

## Interface
- `NUM_CELLS`, 4: ship length in cells, 1..5.
- `GRID_N`, 8: grid size per axis; coordinates are 1..`GRID_N`.
- `X0`, 16: left pixel of grid column 1.
- `Y0`, 16: top pixel of grid row `GRID_N`.
- `PITCH_X`, 62: column pitch, pixels.
- `PITCH_Y`, 57: row pitch, pixels.
- `CELL_W`, 54: cell width, pixels.
- `CELL_H`, 49: cell height, pixels.
- `COR`, 3'b101: {r,g,b} colour of intact cells.
- `COR_HIT`, 3'b111: {r,g,b} colour of hit cells.
- `BLINK_FRAMES`, 30: frames per blink half-period; only used with the blink macro.
- `clk`, in, 1: system clock.
- `rst`, in, 1: synchronous reset, active-high.
- `areaAtiva`, in, 1: the current pixel is in the active video area.
- `linha`, in, 10: current pixel row, increasing downward.
- `coluna`, in, 10: current pixel column.
- `inicioQuadro`, in, 1: one-cycle pulse at start of frame.
- `posicoesEmbarcacao`, in, 8*NUM_CELLS: cell i occupies bits [8i+7:8i], with X in [8i+3:8i] and Y in [8i+7:8i+4].
- `acertos`, in, NUM_CELLS: per-cell hit flags, sampled with the positions.
- `atualiza`, in, 1: update request.
- `pronto`, out, 1: one-cycle pulse when a new position set has been committed.
- `ocupado`, out, 1: high while an update is pending or decoding.
- `rgb_r`, `rgb_g`, `rgb_b`, out, 1 each: colour channels.

## Operation
- **FSM states.**
  - IDLE: on `atualiza`=1, capture `posicoesEmbarcacao` and `acertos` into an input buffer and go to WAIT_FRAME.
  - WAIT_FRAME: on `inicioQuadro`, go to DECODE with index=0.
  - DECODE: decode one cell per cycle into shadow registers, index 0..NUM_CELLS-1. On the last cell, go to COMMIT.
  - COMMIT: copy all shadow registers into live registers in one cycle, pulse `pronto`, then go to IDLE. If a request is pending, go to WAIT_FRAME instead.
- **Request handling.**
  - An `atualiza` that arrives while not in IDLE sets a one-deep pending flag.
  - The pending request captures the inputs present when it was raised. Any later request overwrites it; the last one wins.
  - `ocupado` = (state != IDLE) | pending.
- **Cell decode.**
  - A cell is valid if 1 <= X <= `GRID_N` and 1 <= Y <= `GRID_N`. Otherwise the cell is disabled and draws nothing.
  - left = `X0` + (X-1)*`PITCH_X`.
  - top = `Y0` + (`GRID_N`-Y)*`PITCH_Y`. Y=`GRID_N` is the top row.
  - Bounds are computed in 11 bits; right = left+`CELL_W` and bottom = top+`CELL_H` never wrap.
- **Pixel test.** A pixel is inside a cell when top < `linha` < bottom and left < `coluna` < right. All comparisons are strict.
- **Colour selection.**
  - If any hit cell covers the pixel, output `COR_HIT`.
  - Otherwise, if any intact cell covers the pixel, output `COR`.
  - Otherwise output 0.
  - Output is 0 whenever `areaAtiva`=0.
- **Live registers.** Live bounds change only in COMMIT. Rendering uses the old set throughout WAIT_FRAME and DECODE.

## Timing
- **Reset.**
  - All outputs go to 0.
  - All live and shadow cells are disabled.
  - FSM goes to IDLE; pending flag and blink counter are cleared.
  - Reset asserted mid-DECODE aborts the update; no `pronto` is produced.
- **Pixel latency.** RGB is registered: the value for (`linha`,`coluna`,`areaAtiva`) sampled at edge t appears after edge t+1. Latency is exactly 1 cycle.
- **Update latency.** From the `inicioQuadro` edge, DECODE takes `NUM_CELLS` cycles and COMMIT takes 1 cycle. `pronto` is high for exactly 1 cycle, in the COMMIT cycle.
- **Simultaneous events.**
  - If `atualiza` and `inicioQuadro` are both high in IDLE, the block captures and waits for the next frame start; the same-cycle pulse is not used.
  - If `atualiza` is high in the COMMIT cycle, it is taken as pending.
- **Non-pulse strobes.** `inicioQuadro` high for more than one cycle is treated as one event on its rising edge.

## Configuration
- **Macro `VGA_EMBARCACAO_BLINK_EN`.**
  - With the macro defined: a frame counter counts `inicioQuadro` pulses, 0..`BLINK_FRAMES`-1, and wraps. A phase bit toggles on each wrap.
  - Hit cells draw `COR_HIT` when phase=0 and draw nothing when phase=1, so intact cells beneath show through or the pixel is 0.
  - Counter and phase reset to 0.
- **Without the macro:** no counter is built, and hit cells always draw `COR_HIT`.

## Test plan
- **Reset:** hold `rst` for 3 cycles while driving any pixel -> rgb=000, `pronto`=0, `ocupado`=0.
- **Single cell edges:** NUM_CELLS=4, cell0 X=1 Y=8, others X=0. Pulse `atualiza`, then `inicioQuadro` -> `pronto` 5 cycles after the `inicioQuadro` edge. Then:
  - (linha 20, coluna 20) -> rgb=101 one cycle later.
  - coluna 16 and coluna 70 -> 000.
  - coluna 69 -> 101.
  - linha 65 -> 000.
- **Hit colour:** cell1 X=8 Y=1, `acertos`=4'b0010 -> pixel (linha 420, coluna 460) = 111; `areaAtiva`=0 at the same pixel -> 000.
- **Atomic commit:** move cell0 from X=1 to X=2 during a frame -> pixel (20,20) stays 101 until COMMIT, then 000; pixel (20,80) becomes 101.
- **Pending request:** raise `atualiza` during DECODE -> `ocupado` stays high after the first `pronto`; a second `pronto` follows the next `inicioQuadro`.
- **Blink (with macro, BLINK_FRAMES=2):** hit cell -> 111 for 2 frames, 000 for 2 frames, then repeats.
